// File: rtl/up_down_counter.sv
// Purpose: presettable modulo-N up/down counter (decade by default) with terminal-count flags.
// Latency: q updates one clk edge after load/count is sampled; tcu/tcd are combinational from q and enables.
// Backpressure: none; every edge either loads, counts or holds, and the counter never stalls.
module up_down_counter #(
  parameter int MODULUS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pl,
  input  logic       up,
  input  logic       down,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       tcu,
  output logic       tcd
);

  // Highest in-range count; anything above it is reachable only by a parallel load.
  localparam logic [3:0] MAX_COUNT = 4'(MODULUS - 1);

  // Counting happens only when exactly one direction is requested; up==down means hold.
  logic count_up;
  logic count_down;
  logic [3:0] q_inc;
  logic [3:0] q_dec;

  assign count_up   = up & ~down;
  assign count_down = down & ~up;

  // Next values for each direction. Out-of-range loaded values wrap to 0 going up
  // and simply step down by one, so q never leaves 0..15 and never needs a carry bit.
  always_comb begin
    q_inc = q + 4'd1;
    q_dec = q - 4'd1;
    if (q >= MAX_COUNT) begin
      q_inc = 4'd0;
    end
    if (q == 4'd0) begin
      q_dec = MAX_COUNT;
    end
  end

  // Count register: reset beats load, load beats count, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 4'd0;
    end else if (!pl) begin
      q <= d;
    end else if (count_up) begin
      q <= q_inc;
    end else if (count_down) begin
      q <= q_dec;
    end
  end

  // Terminal-count flags look at the present q and enables only, so a pending load
  // does not mask them; the exclusive enables guarantee they are never both high.
  always_comb begin
    tcu = count_up   && (q == MAX_COUNT);
    tcd = count_down && (q == 4'd0);
  end

endmodule

// File: tb/tb_up_down_counter.sv
module tb_up_down_counter;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       pl;
  logic       up;
  logic       down;
  logic [3:0] d;
  logic [3:0] q;
  logic       tcu;
  logic       tcd;

  int n_chk  = 0;
  int n_pass = 0;
  int mq     = 0;   // reference count value

  up_down_counter #(.MODULUS(M)) dut (
    .clk   (clk),
    .reset (reset),
    .pl    (pl),
    .up    (up),
    .down  (down),
    .d     (d),
    .q     (q),
    .tcu   (tcu),
    .tcd   (tcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference behaviour written straight from the counter's rules.
  function automatic int model_next(input int cur, input bit pl_n, input bit u,
                                    input bit dn, input int dv);
    if (!pl_n) return dv;
    if (u && !dn) return (cur >= M - 1) ? 0 : cur + 1;
    if (dn && !u) return (cur == 0) ? M - 1 : cur - 1;
    return cur;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".q"}, int'(q), mq);
    chk({tag, ".tcu"}, int'(tcu), int'(up && !down && mq == M - 1));
    chk({tag, ".tcd"}, int'(tcd), int'(down && !up && mq == 0));
  endtask

  task automatic set_in(input bit pl_n, input bit u, input bit dn, input int dv);
    pl   = pl_n;
    up   = u;
    down = dn;
    d    = 4'(dv);
    #1;
  endtask

  // Advance one edge, update the model from the inputs seen at that edge, settle.
  task automatic tick();
    @(posedge clk);
    if (reset) mq = 0;
    else mq = model_next(mq, pl, up, down, int'(d));
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1, 0, 0, 0);
    mq = 0;
    check_all("por");

    // Inputs ignored during reset; tcd still follows q==0 with down only.
    set_in(0, 0, 1, 5);
    tick();
    check_all("rst_hold_load");
    set_in(1, 0, 1, 0);
    check_all("rst_tcd");
    set_in(1, 0, 0, 0);
    reset = 1'b0;
    #1;

    // Async reset between edges.
    set_in(0, 0, 0, 7);
    tick();
    check_all("load7");
    set_in(1, 0, 0, 0);
    #3 reset = 1'b1;
    #1 mq = 0;
    check_all("async_rst");
    reset = 1'b0;
    #1;

    // Load 5 then count up through the wrap.
    set_in(0, 0, 0, 5);
    tick();
    check_all("load5");
    set_in(1, 1, 0, 0);
    check_all("up_pre");
    repeat (5) begin
      tick();
      check_all("up");
    end

    // Count down from 0 with wrap.
    set_in(1, 0, 1, 0);
    check_all("dn_pre");
    repeat (5) begin
      tick();
      check_all("dn");
    end

    // Load beats count, then hold with both enables.
    set_in(0, 0, 0, 3);
    tick();
    check_all("load3");
    set_in(0, 1, 0, 8);
    tick();
    check_all("load_prio");
    set_in(1, 1, 1, 0);
    repeat (3) begin
      tick();
      check_all("hold");
    end

    // Out-of-range loads.
    set_in(0, 0, 0, 14);
    tick();
    check_all("load14");
    set_in(1, 1, 0, 0);
    check_all("oor_up_pre");
    tick();
    check_all("oor_up");
    set_in(0, 0, 0, 14);
    tick();
    set_in(1, 0, 1, 0);
    tick();
    check_all("oor_dn");

    // Reset held across a load edge, then load after release.
    set_in(0, 0, 0, 9);
    reset = 1'b1;
    tick();
    check_all("rst_load");
    reset = 1'b0;
    #1;
    tick();
    check_all("load_after_rst");

    // Randomized traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 5) != 0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)));
      check_all("rnd_pre");
      tick();
      check_all("rnd");
      if ($urandom_range(0, 19) == 0) begin
        #2 reset = 1'b1;
        #1 mq = 0;
        check_all("rnd_arst");
        reset = 1'b0;
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
